// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI frame decoder
package spi_pkg;

    typedef enum logic [2:0] {
        S_CMD  = 3'd0,
        S_ADDR = 3'd1,
        S_DHI  = 3'd2,
        S_DLO  = 3'd3,
        S_CK   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_OPCODE = 2'd1;
    localparam logic [1:0] ERR_CKSUM  = 2'd2;
    localparam logic [1:0] ERR_TRUNC  = 2'd3;

    localparam int FRAME_BYTES = 5;

    localparam logic [7:0] CMD_WRITE_DEF = 8'hA5;
    localparam logic [7:0] CMD_NOP_DEF   = 8'h00;
    localparam int         ERR_CNT_W_DEF = 8;

endpackage

// File: rtl/spi_sat_counter.sv
// rtl/spi_sat_counter.sv - saturating up-counter with increment enable
module spi_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // count up on inc, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/spi_frame_decoder.sv
// rtl/spi_frame_decoder.sv - assembles and validates 5-byte SPI command frames
module spi_frame_decoder
    import spi_pkg::*;
#(
    parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF,
    parameter logic [7:0] CMD_NOP   = CMD_NOP_DEF,
    parameter int         ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic                 sclk,
    input  logic                 rst_n,
    input  logic                 ss,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 reg_wr_en,
    output logic [7:0]           reg_addr,
    output logic [15:0]          reg_wdata,
    output logic                 frame_ok,
    output logic                 frame_err,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    state_t     state;
    logic [7:0] cmd;
    logic [7:0] addr;
    logic [7:0] dhi;
    logic [7:0] dlo;
    logic [7:0] acc;

    // The partial flag is set from the ss domain and cleared from the sclk
    // domain, so it is kept as a pair of toggles whose difference is the flag.
    logic set_tog;
    logic clr_tog;
    logic partial;

    logic byte_in;
    logic cmd_ok;
    logic cksum_ok;
    logic frame_good;
    logic trunc_hit;
    logic eval_hit;
    logic err_fire;

    assign partial    = set_tog ^ clr_tog;
    assign byte_in    = byte_valid && !ss;
    assign cmd_ok     = (cmd == CMD_WRITE) || (cmd == CMD_NOP);
    assign cksum_ok   = (acc == byte_data);
    assign frame_good = cmd_ok && cksum_ok;
    assign trunc_hit  = byte_in && (state == S_CMD) && partial;
    assign eval_hit   = byte_in && (state == S_CK);
    assign err_fire   = trunc_hit || (eval_hit && !frame_good);
    assign busy       = (state != S_CMD);

    // frame position, checksum and status pulses; ss high aborts the frame
    always_ff @(posedge sclk or negedge rst_n or posedge ss) begin
        if (!rst_n) begin
            state     <= S_CMD;
            acc       <= '0;
            reg_wr_en <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else if (ss) begin
            state     <= S_CMD;
            acc       <= '0;
            reg_wr_en <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (byte_valid) begin
                case (state)
                    S_CMD: begin
                        acc       <= byte_data;
                        frame_err <= partial;
                        state     <= S_ADDR;
                    end
                    S_ADDR: begin
                        acc   <= acc ^ byte_data;
                        state <= S_DHI;
                    end
                    S_DHI: begin
                        acc   <= acc ^ byte_data;
                        state <= S_DLO;
                    end
                    S_DLO: begin
                        acc   <= acc ^ byte_data;
                        state <= S_CK;
                    end
                    S_CK: begin
                        frame_ok  <= frame_good;
                        frame_err <= !frame_good;
                        reg_wr_en <= frame_good && (cmd == CMD_WRITE);
                        state     <= S_CMD;
                    end
                    default: state <= S_CMD;
                endcase
            end
        end
    end

    // frame byte capture, write address/data and held error code
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cmd       <= '0;
            addr      <= '0;
            dhi       <= '0;
            dlo       <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            err_code  <= ERR_NONE;
            clr_tog   <= 1'b0;
        end else if (byte_in) begin
            case (state)
                S_CMD: begin
                    cmd <= byte_data;
                    if (partial) begin
                        err_code <= ERR_TRUNC;
                        clr_tog  <= set_tog;
                    end
                end
                S_ADDR: addr <= byte_data;
                S_DHI:  dhi  <= byte_data;
                S_DLO:  dlo  <= byte_data;
                S_CK: begin
                    if (!cmd_ok) begin
                        err_code <= ERR_OPCODE;
                    end else if (!cksum_ok) begin
                        err_code <= ERR_CKSUM;
                    end else begin
                        err_code <= ERR_NONE;
                        if (cmd == CMD_WRITE) begin
                            reg_addr  <= addr;
                            reg_wdata <= {dhi, dlo};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // mark a truncated frame when ss rises while a frame is in progress
    always_ff @(posedge ss or negedge rst_n) begin
        if (!rst_n) begin
            set_tog <= 1'b0;
        end else if ((state != S_CMD) && !partial) begin
            set_tog <= ~set_tog;
        end
    end

    spi_sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (sclk),
        .rst_n (rst_n),
        .inc   (err_fire),
        .count (err_count)
    );

endmodule

// File: tb/tb_spi_frame_decoder.sv
// tb/tb_spi_frame_decoder.sv - self-checking bench for spi_frame_decoder
module tb_spi_frame_decoder;

    logic        sclk = 1'b0;
    logic        rst_n;
    logic        ss;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        reg_wr_en;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [7:0]  err_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // reference state
    logic [7:0]  exp_addr;
    logic [15:0] exp_wdata;
    logic [1:0]  exp_code;
    int          exp_count;
    bit          exp_partial;

    spi_frame_decoder dut (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .ss         (ss),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .reg_wr_en  (reg_wr_en),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_addr    = 8'h00;
        exp_wdata   = 16'h0000;
        exp_code    = 2'd0;
        exp_count   = 0;
        exp_partial = 1'b0;
    endtask

    task automatic count_err();
        if (exp_count < 255) exp_count++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge sclk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic check_all_held(input string tag);
        chk({tag, "_addr"},  reg_addr,  exp_addr);
        chk({tag, "_wdata"}, reg_wdata, exp_wdata);
        chk({tag, "_code"},  err_code,  exp_code);
        chk({tag, "_count"}, err_count, exp_count);
    endtask

    // send a full frame and compare its outcome with the frame rules
    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] k, input int gap);
        logic [7:0] fb [5];
        int         code;
        bit         wr;
        fb = '{c, a, h, l, k};
        for (int i = 0; i < 5; i++) begin
            send_byte(fb[i]);
            if (i == 0) begin
                if (exp_partial) begin
                    chk("trunc_err",  frame_err, 1);
                    chk("trunc_code", err_code, 3);
                    exp_code    = 2'd3;
                    exp_partial = 1'b0;
                    count_err();
                end else begin
                    chk("pulses_clear", {reg_wr_en, frame_ok, frame_err}, 0);
                end
                chk("count_at_cmd", err_count, exp_count);
            end
            if (i < 4) begin
                chk("busy_mid", busy, 1);
                idle(gap);
            end
        end
        if ((c != 8'hA5) && (c != 8'h00)) code = 1;
        else if ((c ^ a ^ h ^ l) != k)    code = 2;
        else                              code = 0;
        wr = (code == 0) && (c == 8'hA5);
        if (wr) begin
            exp_addr  = a;
            exp_wdata = {h, l};
        end
        exp_code = code[1:0];
        if (code != 0) count_err();
        chk("frame_ok",  frame_ok,  (code == 0));
        chk("frame_err", frame_err, (code != 0));
        chk("reg_wr_en", reg_wr_en, wr);
        chk("busy_end",  busy, 0);
        check_all_held("frame");
    endtask

    initial begin
        logic [7:0] rc, ra, rh, rl, rk;
        rst_n      = 1'b0;
        ss         = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        model_reset();
        idle(3);

        // reset state
        chk("rst_wr_en", reg_wr_en, 0);
        chk("rst_ok",    frame_ok, 0);
        chk("rst_err",   frame_err, 0);
        chk("rst_busy",  busy, 0);
        check_all_held("rst");
        rst_n = 1'b1;
        idle(2);

        // directed write, then pulse width one cycle
        send_frame(8'hA5, 8'h10, 8'h12, 8'h34, 8'h93, 1);
        idle(1);
        chk("wr_pulse_width", reg_wr_en, 0);
        chk("ok_pulse_width", frame_ok, 0);

        // NOP keeps previous write data
        send_frame(8'h00, 8'h05, 8'h00, 8'h00, 8'h05, 2);
        idle(1);

        // bad checksum then bad opcode
        send_frame(8'hA5, 8'h10, 8'h12, 8'h34, 8'h00, 0);
        idle(1);
        send_frame(8'h77, 8'h01, 8'h02, 8'h03, 8'h77, 1);
        idle(1);

        // bytes while ss high are ignored
        ss = 1'b1;
        idle(1);
        send_byte(8'hA5);
        send_byte(8'h10);
        chk("ss_ignore_busy", busy, 0);
        chk("ss_ignore_err",  frame_err, 0);
        ss = 1'b0;
        idle(1);

        // ss rising clears a completed frame's pulse without a clock edge
        send_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        ss = 1'b1;
        #1;
        chk("ss_async_ok_clear", frame_ok, 0);
        idle(1);
        ss = 1'b0;
        idle(1);

        // truncation: two bytes, ss abort, then a full valid write
        send_byte(8'hA5);
        send_byte(8'h10);
        chk("trunc_busy_before", busy, 1);
        ss = 1'b1;
        #1;
        chk("trunc_busy_after_ss", busy, 0);
        exp_partial = 1'b1;
        check_all_held("trunc_held");
        idle(2);
        ss = 1'b0;
        idle(1);
        send_frame(8'hA5, 8'h22, 8'hBE, 8'hEF, 8'hA5 ^ 8'h22 ^ 8'hBE ^ 8'hEF, 1);
        idle(1);

        // randomized frames, mostly valid opcodes, some checksum damage
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       rc = 8'h00;
                3:       rc = 8'($urandom);
                default: rc = 8'hA5;
            endcase
            ra = 8'($urandom);
            rh = 8'($urandom);
            rl = 8'($urandom);
            rk = rc ^ ra ^ rh ^ rl;
            if ($urandom_range(0, 9) < 3) rk = rk ^ 8'($urandom_range(1, 255));
            send_frame(rc, ra, rh, rl, rk, $urandom_range(0, 2));
            idle($urandom_range(0, 2));
        end

        // back-to-back writes, then async reset mid-third-frame
        send_frame(8'hA5, 8'h31, 8'h55, 8'hAA, 8'hA5 ^ 8'h31 ^ 8'h55 ^ 8'hAA, 0);
        send_frame(8'hA5, 8'h42, 8'h0F, 8'hF0, 8'hA5 ^ 8'h42 ^ 8'h0F ^ 8'hF0, 0);
        send_byte(8'hA5);
        chk("b2b_clear", reg_wr_en, 0);
        send_byte(8'h50);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_wr_en", reg_wr_en, 0);
        chk("mid_rst_busy",  busy, 0);
        chk("mid_rst_err",   frame_err, 0);
        check_all_held("mid_rst");
        idle(1);
        rst_n = 1'b1;
        idle(1);

        // 260 bad-checksum frames saturate the error counter
        for (int n = 0; n < 260; n++) begin
            send_frame(8'hA5, 8'h10, 8'h12, 8'h34, 8'h00, 0);
        end
        chk("sat_count", err_count, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
